ram_line_packer: RTL and testbench

Write-side front end for the 8-entry × 128-bit single-port line RAM. It accepts a stream of 32-bit words over a valid/ready handshake and packs four consecutive words into one 128-bit line. It issues one single-cycle write per line to the RAM at ascending addresses 0..DEPTH-1, and stops accepting data once every entry has been written. A packet-end marker flushes a partially filled line with zero padding.

---
 rtl/ram_line_packer.sv | 111 +++++++++++
 tb/tb_ram_line_packer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_line_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_line_packer                                                 |
// | Brief    : Packs a valid/ready word stream into zero-padded RAM lines and  |
// |            writes them once each to ascending addresses until full.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ram_line_packer #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic [WORD_W-1:0]                  s_data,
  input  logic                               s_valid,
  input  logic                               s_last,
  output logic                               s_ready,
  output logic                               ram_wr_en,
  output logic [ADDR_W-1:0]                  ram_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0]   ram_data_in,
  output logic [ADDR_W:0]                    lines_written,
  output logic                               full
);

  localparam int c_LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int c_LANE_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_LANE_W-1:0]   r_lane;
  logic [c_LINE_W-1:0]   r_buf;
  logic [ADDR_W-1:0]     r_ptr;
  logic [ADDR_W:0]       r_lines;

  logic                  w_accept;
  logic                  w_close;
  logic [c_LINE_W-1:0]   w_line;

  // rst_n is folded in so the block never advertises ready while held in reset.
  assign s_ready  = rst_n && (r_state != ST_FULL) && !clear;
  assign w_accept = s_valid && s_ready;
  assign w_close  = w_accept && ((r_lane == c_LAST_LANE) || s_last);

  always_comb begin
    w_line = r_buf;
    w_line[r_lane*WORD_W +: WORD_W] = s_data;
  end

  assign lines_written = r_lines;
  assign full          = (r_state == ST_FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_lane      <= '0;
      r_buf       <= '0;
      r_ptr       <= '0;
      r_lines     <= '0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else if (clear) begin
      // Restart without touching the last written address/data.
      r_state   <= ST_EMPTY;
      r_lane    <= '0;
      r_buf     <= '0;
      r_ptr     <= '0;
      r_lines   <= '0;
      ram_wr_en <= 1'b0;
    end else begin
      ram_wr_en <= 1'b0;
      case (r_state)
        ST_EMPTY, ST_PARTIAL: begin
          if (w_close) begin
            ram_data_in <= w_line;
            ram_addr    <= r_ptr;
            ram_wr_en   <= 1'b1;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_lines     <= r_lines + (ADDR_W+1)'(1);
            r_buf       <= '0;
            r_lane      <= '0;
            r_state     <= (r_ptr == c_LAST_ADDR) ? ST_FULL : ST_EMPTY;
          end else if (w_accept) begin
            r_buf   <= w_line;
            r_lane  <= r_lane + c_LANE_W'(1);
            r_state <= ST_PARTIAL;
          end
        end
        ST_FULL: begin
          r_state <= ST_FULL;
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_line_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_line_packer                                              |
// | Brief    : Scoreboard bench for ram_line_packer with a queue-based model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ram_line_packer;

  localparam int c_WORD_W = 32;
  localparam int c_WPL    = 4;
  localparam int c_DEPTH  = 8;
  localparam int c_ADDR_W = 3;
  localparam int c_LINE_W = c_WORD_W * c_WPL;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clear = 1'b0;
  logic [c_WORD_W-1:0]   s_data = '0;
  logic                  s_valid = 1'b0;
  logic                  s_last = 1'b0;
  logic                  s_ready;
  logic                  ram_wr_en;
  logic [c_ADDR_W-1:0]   ram_addr;
  logic [c_LINE_W-1:0]   ram_data_in;
  logic [c_ADDR_W:0]     lines_written;
  logic                  full;

  ram_line_packer #(
    .WORD_W(c_WORD_W), .WORDS_PER_LINE(c_WPL), .DEPTH(c_DEPTH), .ADDR_W(c_ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .lines_written(lines_written), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [c_ADDR_W-1:0] addr;
    logic [c_LINE_W-1:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;

  // Reference model: words of the line being assembled, plus counters.
  logic [c_WORD_W-1:0] m_words[$];
  wr_t                 sb[$];
  int                  m_ptr = 0;
  int                  m_lines = 0;
  bit                  m_full = 0;
  bit                  m_wr = 0;
  logic [c_ADDR_W-1:0] m_addr = '0;
  logic [c_LINE_W-1:0] m_data = '0;
  bit                  mon_en = 0;

  task automatic cycle(input logic rst, input logic clr, input logic v,
                       input logic last, input logic [c_WORD_W-1:0] d);
    logic exp_ready;
    logic [c_LINE_W-1:0] line;
    wr_t e;
    rst_n = rst; clear = clr; s_valid = v; s_last = last; s_data = d;
    @(negedge clk);
    exp_ready = rst && !m_full && !clr;
    checks++;
    if (s_ready !== exp_ready) begin
      errors++;
      $display("FAIL s_ready: got %b expected %b at %0t", s_ready, exp_ready, $time);
    end
    @(posedge clk);
    m_wr = 0;
    if (!rst) begin
      m_words.delete(); m_ptr = 0; m_lines = 0; m_full = 0; m_addr = '0; m_data = '0;
    end else if (clr) begin
      m_words.delete(); m_ptr = 0; m_lines = 0; m_full = 0;
    end else if (v && exp_ready) begin
      m_words.push_back(d);
      if (m_words.size() == c_WPL || last) begin
        line = '0;
        foreach (m_words[i]) line[i*c_WORD_W +: c_WORD_W] = m_words[i];
        e.addr = c_ADDR_W'(m_ptr);
        e.data = line;
        sb.push_back(e);
        m_addr = e.addr; m_data = line; m_wr = 1;
        m_ptr++; m_lines++;
        if (m_lines == c_DEPTH) m_full = 1;
        m_words.delete();
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      checks++;
      if (ram_wr_en !== m_wr) begin
        errors++;
        $display("FAIL ram_wr_en: got %b expected %b at %0t", ram_wr_en, m_wr, $time);
      end
      if (ram_wr_en === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL write: got unexpected write addr %0d, expected none at %0t", ram_addr, $time);
        end else begin
          e = sb.pop_front();
          checks++;
          if (ram_addr !== e.addr || ram_data_in !== e.data) begin
            errors++;
            $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                     ram_addr, ram_data_in, e.addr, e.data);
          end
        end
      end else begin
        checks++;
        if (ram_addr !== m_addr || ram_data_in !== m_data) begin
          errors++;
          $display("FAIL hold: got addr %0d data %h expected addr %0d data %h",
                   ram_addr, ram_data_in, m_addr, m_data);
        end
      end
      checks++;
      if (lines_written !== (c_ADDR_W+1)'(m_lines) || full !== m_full) begin
        errors++;
        $display("FAIL status: got lines %0d full %b expected lines %0d full %b at %0t",
                 lines_written, full, m_lines, m_full, $time);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, '0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1;
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);

    // Four back-to-back words form line 0.
    cycle(1, 0, 1, 0, 32'h11111111);
    cycle(1, 0, 1, 0, 32'h22222222);
    cycle(1, 0, 1, 0, 32'h33333333);
    cycle(1, 0, 1, 0, 32'h44444444);
    idle(2);
    checks++;
    if (m_data !== 128'h44444444_33333333_22222222_11111111) begin
      errors++;
      $display("FAIL first_line: got %h expected 44444444333333332222222211111111", m_data);
    end

    // 33 continuous words fill all lines; the last is refused.
    cycle(1, 1, 0, 0, '0);
    for (int i = 0; i < 33; i++) cycle(1, 0, 1, 0, 32'h1000 + i);
    idle(3);

    // Short packet closes with zero padding; next word starts line 1.
    cycle(1, 1, 0, 0, '0);
    cycle(1, 0, 1, 0, 32'hAAAAAAAA);
    cycle(1, 0, 1, 1, 32'hBBBBBBBB);
    cycle(1, 0, 1, 0, 32'hCCCCCCCC);
    cycle(1, 0, 1, 1, 32'hDDDDDDDD);
    idle(2);

    // Clear with a word presented discards the partial line.
    cycle(1, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 32'h2000 + i);
    cycle(1, 1, 1, 0, 32'h2003);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 32'h3000 + i);
    idle(2);

    // Reset mid-line discards the partial line.
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 32'h4000 + i);
    cycle(0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 32'h5000 + i);
    idle(2);

    // Randomised traffic with stalls, packet ends, clears and resets.
    for (int i = 0; i < 600; i++) begin
      logic r, c, v, l;
      r = ($urandom_range(0, 99) >= 1);
      c = m_full ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 99) < 15);
      cycle(r, c, v, l, $urandom);
    end
    idle(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending writes expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
